ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter for the keyboard port; the transmit half of the PS/2 link, whose receive half decodes scancodes. It accepts one command byte at a time (LED set 0xED, reset 0xFF, typematic 0xF3, …), runs the inhibit / request-to-send / device-clocked frame / acknowledge sequence, and reports done or error. It drives the open-drain pads through the existing `*_out` convention: 1 releases the line (pad Z), 0 pulls it low.

## Interface
- `SYSCLK_FREQ`, default 240: system clock in 100 kHz units (240 = 24.0 MHz).
- `INHIBIT_US`, default 120: clock-low inhibit time before the start bit, in µs.
- `TIMEOUT_MS`, default 15: maximum time from clock release to acknowledge, in ms.
- `clk_sys`  in  1: system clock; every register is on its rising edge.
- `res_n`  in  1: asynchronous, active-low reset.
- `tx_data`  in  8: command byte; sampled when `tx_valid & tx_ready`.
- `tx_valid`  in  1: request to send.
- `tx_ready`  out  1: high only in IDLE.
- `tx_busy`  out  1: high in every state except IDLE; the keyboard receiver ignores the bus while it is high.
- `tx_done`  out  1: one-cycle pulse when the device has acknowledged.
- `tx_err`  out  1: one-cycle pulse on timeout or missing acknowledge.
- `ps2_clk_in`  in  1: PS/2 clock pad level.
- `ps2_dat_in`  in  1: PS/2 data pad level.
- `ps2_clk_out`  out  1: 0 pulls the clock low, 1 releases it.
- `ps2_dat_out`  out  1: 0 pulls data low, 1 releases it.

## Operation
- `ps2_clk_in` and `ps2_dat_in` pass through 2-FF synchronizers. The falling-edge detector works on the synchronized clock (filtered when the macro is on).
- Frame held in an 11-bit shift register: {stop=1, parity, d7..d0}, bits shifted out LSB first. The start bit is the data-low driven in RTS.
- Parity is odd: parity = ~^tx_data.
- States and transitions:
  - **IDLE**: both lines released. On `tx_valid`, latch the frame and go to INHIBIT.
  - **INHIBIT**: `ps2_clk_out`=0 for INHIBIT_US·SYSCLK_FREQ/10 cycles (2880 by default).
  - **RTS**: `ps2_dat_out`=0 while `ps2_clk_out`=0 for 1 cycle, then release the clock. Start the timeout counter and go to SEND.
  - **SEND**: on each device clock falling edge, drive the next frame bit onto `ps2_dat_out` (0 drives low, 1 releases). After the 10th falling edge (stop bit driven released), go to ACK.
  - **ACK**: on the 11th falling edge, sample the synchronized data. Low means acknowledged, go to WAIT_IDLE. High raises `tx_err` and goes to IDLE.
  - **WAIT_IDLE**: wait until both synchronized lines read high, then pulse `tx_done` and go to IDLE.
- Timeout counter, TIMEOUT_MS·SYSCLK_FREQ·100 cycles (360 000 by default, 19 bits):
  - runs from clock release through WAIT_IDLE;
  - on expiry in any of those states: pulse `tx_err`, release both lines, return to IDLE.
- Counter widths are $clog2 of the computed count values. All arithmetic is unsigned; counters saturate at their terminal count and never wrap.
- Reset mid-frame releases both lines immediately, because the outputs are asynchronously reset. No done or error pulse is produced.
- Simultaneous events:
  - `tx_valid` while busy is ignored; the byte is not queued.
  - Timeout expiring on the same cycle as the ACK edge: acknowledge wins.
  - A device transmission in progress when the request arrives is aborted by INHIBIT, as the PS/2 protocol allows. The receiver discards the partial byte because `tx_busy` is high.

## Timing
- Reset values: `ps2_clk_out`=1, `ps2_dat_out`=1, `tx_ready`=1, `tx_busy`=0, `tx_done`=0, `tx_err`=0.
- `tx_ready` falls on the cycle after acceptance.
- `ps2_clk_out` goes low on the cycle after acceptance.
- Data changes at most 3 cycles after a pad clock falling edge (2 sync + 1 register), plus the filter latency when enabled. This is well inside the device's ≥5 µs hold window.
- `tx_done` and `tx_err` are registered and exactly one cycle wide. `tx_ready` returns high on the same cycle as the pulse.

## Configuration
- `PS2_TX_FILTER_EN`:
  - Defined: the synchronized clock passes through an 8-sample majority/hysteresis filter. The filtered level changes only after 8 consecutive equal samples, which adds 8 cycles of edge latency and rejects glitches shorter than 8 cycles.
  - Undefined: the edge detector uses the 2-FF synchronized clock directly.

## Structure
- Package `ps2_pkg`: state enum `ps2_tx_state_t`, odd-parity function, and localparam helpers computing the inhibit and timeout counts from the parameters. The keyboard receiver shares this package.
- One sub-module, `ps2_line_sync`: synchronizer, optional filter and falling-edge strobe. It is instantiated for the clock line; the data line uses its synchronizer only.

## Test plan
- Send 0xED with the device model clocking at 12.5 kHz and acknowledging:
  - clock low ≥2880 cycles, then data low;
  - sampled bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - one `tx_done` pulse, no `tx_err`.
- Send 0x00: parity bit 1. Send 0x01: parity bit 0. Both complete with `tx_done`.
- Device never clocks after RTS: `tx_err` exactly 360 000 cycles after clock release, both lines released, `tx_ready`=1.
- Device clocks 11 edges but leaves data high at ACK: `tx_err` on the 11th edge, no `tx_done`.
- Drop `res_n` after the 5th data bit: both outputs 1 immediately, no pulse. A new 0xFF after reset completes normally.
- With `PS2_TX_FILTER_EN`, inject 4-cycle low glitches on the clock mid-frame: bit order is unchanged and the frame completes. Without the macro, the same glitch advances the bit counter, which is the documented behaviour.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, odd parity and cycle-count helpers.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INHIBIT,
      ST_RTS,
      ST_SEND,
      ST_ACK,
      ST_WAIT_IDLE
   } ps2_tx_state_t;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

   // freq is in 100 kHz units, so cycles per microsecond = freq / 10
   function automatic int unsigned inhibit_cycles(input int unsigned us, input int unsigned freq);
      return us * freq / 10;
   endfunction

   function automatic int unsigned timeout_cycles(input int unsigned ms, input int unsigned freq);
      return ms * freq * 100;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 pad synchronizer with falling-edge strobe; PS2_TX_FILTER_EN adds an 8-sample glitch filter.
module ps2_line_sync (
   input  logic clk_sys,
   input  logic res_n,
   input  logic pad,
   output logic level,
   output logic fall
);

   logic [1:0] sync;
   logic       prev;

   always_ff @(posedge clk_sys or negedge res_n) begin
      if (!res_n) sync <= 2'b11;
      else        sync <= {sync[0], pad};
   end

`ifdef PS2_TX_FILTER_EN
   logic [6:0] hist;
   logic [7:0] window;
   logic       filt;

   assign window = {hist, sync[1]};

   // level moves only once the last eight samples agree
   always_ff @(posedge clk_sys or negedge res_n) begin
      if (!res_n) begin
         hist <= '1;
         filt <= 1'b1;
      end else begin
         hist <= window[6:0];
         if (&window)       filt <= 1'b1;
         else if (~|window) filt <= 1'b0;
      end
   end

   assign level = filt;
`else
   assign level = sync[1];
`endif

   always_ff @(posedge clk_sys or negedge res_n) begin
      if (!res_n) prev <= 1'b1;
      else        prev <= level;
   end

   assign fall = prev & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, device-clocked frame, acknowledge.
// Build option PS2_TX_FILTER_EN filters the device clock before edge detection.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int unsigned SYSCLK_FREQ = 240,
   parameter int unsigned INHIBIT_US  = 120,
   parameter int unsigned TIMEOUT_MS  = 15
) (
   input  logic       clk_sys,
   input  logic       res_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic       ps2_clk_out,
   output logic       ps2_dat_out
);

   localparam int unsigned INH_CYC = inhibit_cycles(INHIBIT_US, SYSCLK_FREQ);
   localparam int unsigned TO_CYC  = timeout_cycles(TIMEOUT_MS, SYSCLK_FREQ);
   localparam int INH_W = cnt_width(INH_CYC);
   localparam int TO_W  = cnt_width(TO_CYC);
   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_CYC - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 1);

   ps2_tx_state_t    state, state_n;
   logic [10:0]      frame, frame_n;
   logic [3:0]       bit_cnt, bit_n;
   logic [INH_W-1:0] inh_cnt, inh_n;
   logic [TO_W-1:0]  to_cnt, to_n;
   logic             clk_q, clk_n, dat_q, dat_n, done_n, err_n;
   logic             clk_s, clk_fall, to_hit;
   logic [1:0]       dat_sync;
   logic             dat_s;

   ps2_line_sync u_clk_sync (
      .clk_sys (clk_sys),
      .res_n   (res_n),
      .pad     (ps2_clk_in),
      .level   (clk_s),
      .fall    (clk_fall)
   );

   always_ff @(posedge clk_sys or negedge res_n) begin
      if (!res_n) dat_sync <= 2'b11;
      else        dat_sync <= {dat_sync[0], ps2_dat_in};
   end
   assign dat_s = dat_sync[1];

   assign to_hit = (to_cnt == TO_LAST);

   always_comb begin
      state_n = state;
      frame_n = frame;
      bit_n   = bit_cnt;
      inh_n   = inh_cnt;
      to_n    = to_cnt;
      clk_n   = clk_q;
      dat_n   = dat_q;
      done_n  = 1'b0;
      err_n   = 1'b0;
      if ((state == ST_SEND || state == ST_ACK || state == ST_WAIT_IDLE) && !to_hit)
         to_n = to_cnt + 1'b1;
      case (state)
         ST_IDLE: begin
            clk_n = 1'b1;
            dat_n = 1'b1;
            if (tx_valid) begin
               // {stop, parity, data, start}; start bit goes out during RTS
               frame_n = {1'b1, odd_parity(tx_data), tx_data, 1'b0};
               bit_n   = '0;
               inh_n   = '0;
               clk_n   = 1'b0;
               state_n = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (inh_cnt == INH_LAST) begin
               dat_n   = frame[0];
               state_n = ST_RTS;
            end else begin
               inh_n = inh_cnt + 1'b1;
            end
         end
         ST_RTS: begin
            clk_n   = 1'b1;
            to_n    = '0;
            state_n = ST_SEND;
         end
         ST_SEND: begin
            if (to_hit) begin
               err_n   = 1'b1;
               clk_n   = 1'b1;
               dat_n   = 1'b1;
               state_n = ST_IDLE;
            end else if (clk_fall) begin
               dat_n   = frame[1];
               frame_n = {1'b1, frame[10:1]};
               if (bit_cnt == 4'd9) state_n = ST_ACK;
               else                 bit_n   = bit_cnt + 1'b1;
            end
         end
         ST_ACK: begin
            // the acknowledge edge takes precedence over a coincident timeout
            if (clk_fall) begin
               if (!dat_s) begin
                  state_n = ST_WAIT_IDLE;
               end else begin
                  err_n   = 1'b1;
                  state_n = ST_IDLE;
               end
            end else if (to_hit) begin
               err_n   = 1'b1;
               clk_n   = 1'b1;
               dat_n   = 1'b1;
               state_n = ST_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            if (clk_s && dat_s) begin
               done_n  = 1'b1;
               state_n = ST_IDLE;
            end else if (to_hit) begin
               err_n   = 1'b1;
               clk_n   = 1'b1;
               dat_n   = 1'b1;
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge res_n) begin
      if (!res_n) begin
         state   <= ST_IDLE;
         frame   <= '1;
         bit_cnt <= '0;
         inh_cnt <= '0;
         to_cnt  <= '0;
         clk_q   <= 1'b1;
         dat_q   <= 1'b1;
         tx_done <= 1'b0;
         tx_err  <= 1'b0;
      end else begin
         state   <= state_n;
         frame   <= frame_n;
         bit_cnt <= bit_n;
         inh_cnt <= inh_n;
         to_cnt  <= to_n;
         clk_q   <= clk_n;
         dat_q   <= dat_n;
         tx_done <= done_n;
         tx_err  <= err_n;
      end
   end

   assign ps2_clk_out = clk_q;
   assign ps2_dat_out = dat_q;
   assign tx_ready    = (state == ST_IDLE);
   assign tx_busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a device model clocks frames and checks bits against a scoreboard queue.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int FREQ   = 10;   // 1.0 MHz system clock
   localparam int INH_US = 120;
   localparam int TO_MS  = 3;
   localparam int INH    = 120;  // 120 us at 1 MHz
   localparam int TO     = 3000; // 3 ms at 1 MHz
   localparam int HALF   = 40;   // 12.5 kHz device clock

   logic       clk_sys, res_n;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready, tx_busy, tx_done, tx_err;
   logic       ps2_clk_in, ps2_dat_in, ps2_clk_out, ps2_dat_out;
   logic       dev_clk, dev_dat;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int snap_done, snap_err;
   logic exp_q[$];
   logic [15:0] obs_vec;
   int obs_idx;

   assign ps2_clk_in = ps2_clk_out & dev_clk;
   assign ps2_dat_in = ps2_dat_out & dev_dat;

   ps2_host_tx #(
      .SYSCLK_FREQ (FREQ),
      .INHIBIT_US  (INH_US),
      .TIMEOUT_MS  (TO_MS)
   ) dut (
      .clk_sys     (clk_sys),
      .res_n       (res_n),
      .tx_data     (tx_data),
      .tx_valid    (tx_valid),
      .tx_ready    (tx_ready),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .tx_err      (tx_err),
      .ps2_clk_in  (ps2_clk_in),
      .ps2_dat_in  (ps2_dat_in),
      .ps2_clk_out (ps2_clk_out),
      .ps2_dat_out (ps2_dat_out)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) begin
      if (tx_done === 1'b1) done_cnt++;
      if (tx_err === 1'b1)  err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic send(input logic [7:0] d, input bit push);
      snap_done = done_cnt;
      snap_err  = err_cnt;
      obs_idx   = 0;
      obs_vec   = '0;
      if (push) begin
         for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
         exp_q.push_back(~^d);
         exp_q.push_back(1'b1);
      end
      @(negedge clk_sys);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk_sys);
      tx_valid = 1'b0;
      check("ready_fall", tx_ready, 0);
      check("clk_low_after_accept", ps2_clk_out, 0);
   endtask

   task automatic wait_rel();
      int n = 0;
      while (ps2_clk_out !== 1'b1 && n < 10) begin
         @(negedge clk_sys);
         n++;
      end
      check("clk_release", ps2_clk_out, 1);
   endtask

   task automatic wait_rts();
      int low = 0;
      int n = 0;
      while (ps2_dat_out === 1'b1 && n < INH + 100) begin
         if (ps2_clk_out === 1'b0) low++;
         @(negedge clk_sys);
         n++;
      end
      check("inhibit_len_ok", 32'(low >= INH), 1);
      check("rts_clk_low", ps2_clk_out, 0);
      check("rts_dat_low", ps2_dat_out, 0);
      wait_rel();
      check("start_bit", ps2_dat_in, 0);
   endtask

   task automatic dev_clock(input int n);
      logic b;
      for (int i = 0; i < n; i++) begin
         dev_clk = 1'b0;
         cyc(HALF);
         dev_clk = 1'b1;
         if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            check($sformatf("bit%0d", obs_idx), ps2_dat_in, b);
            obs_vec[obs_idx] = ps2_dat_in;
            obs_idx++;
         end
         cyc(HALF);
      end
   endtask

   task automatic dev_ack();
      dev_dat = 1'b0;
      dev_clk = 1'b0;
      cyc(HALF);
      dev_clk = 1'b1;
      cyc(HALF);
      dev_dat = 1'b1;
   endtask

   task automatic finish_frame(input string tag);
      int n = 0;
      while (tx_ready !== 1'b1 && n < 100) begin
         @(negedge clk_sys);
         n++;
      end
      cyc(2);
      check({tag, "_done"}, done_cnt - snap_done, 1);
      check({tag, "_no_err"}, err_cnt - snap_err, 0);
      check({tag, "_sb_empty"}, exp_q.size(), 0);
   endtask

   initial begin
      int cnt;
      res_n    = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      dev_clk  = 1'b1;
      dev_dat  = 1'b1;
      cyc(3);
      check("rst_clk_out", ps2_clk_out, 1);
      check("rst_dat_out", ps2_dat_out, 1);
      check("rst_ready", tx_ready, 1);
      check("rst_busy", tx_busy, 0);
      check("rst_done", tx_done, 0);
      check("rst_err", tx_err, 0);
      res_n = 1'b1;
      cyc(5);

      // 0xED with a second request while busy, which must be dropped
      send(8'hED, 1'b1);
      wait_rts();
      tx_data  = 8'h55;
      tx_valid = 1'b1;
      @(negedge clk_sys);
      tx_valid = 1'b0;
      check("busy_during_frame", tx_busy, 1);
      cyc(18);
      dev_clock(10);
      dev_ack();
      finish_frame("ed");
      check("ed_frame", obs_vec[9:0], 10'b11_1110_1101);
      cyc(50);
      check("no_queued_clk", ps2_clk_out, 1);
      check("no_queued_ready", tx_ready, 1);

      send(8'h00, 1'b1);
      wait_rts();
      cyc(20);
      dev_clock(10);
      dev_ack();
      finish_frame("d00");
      check("par00", obs_vec[8], 1);

      send(8'h01, 1'b1);
      wait_rts();
      cyc(20);
      dev_clock(10);
      dev_ack();
      finish_frame("d01");
      check("par01", obs_vec[8], 0);

      // device silent after RTS
      send(8'hA5, 1'b0);
      wait_rts();
      cnt = 0;
      while (tx_err !== 1'b1 && cnt < TO + 100) begin
         @(negedge clk_sys);
         cnt++;
      end
      check("timeout_cycles", cnt, TO);
      check("timeout_clk_rel", ps2_clk_out, 1);
      check("timeout_dat_rel", ps2_dat_out, 1);
      check("timeout_ready", tx_ready, 1);
      cyc(5);
      check("timeout_err_pulses", err_cnt - snap_err, 1);
      check("timeout_no_done", done_cnt - snap_done, 0);

      // missing acknowledge
      send(8'h3C, 1'b1);
      wait_rts();
      cyc(20);
      dev_clock(10);
      dev_clk = 1'b0;
      cyc(HALF);
      check("nack_err", err_cnt - snap_err, 1);
      check("nack_ready", tx_ready, 1);
      dev_clk = 1'b1;
      cyc(HALF);
      check("nack_no_done", done_cnt - snap_done, 0);

      // reset after the fifth data bit
      send(8'hC3, 1'b1);
      wait_rts();
      cyc(20);
      dev_clock(5);
      res_n = 1'b0;
      #1;
      check("rst_mid_clk", ps2_clk_out, 1);
      check("rst_mid_dat", ps2_dat_out, 1);
      cyc(3);
      check("rst_mid_ready", tx_ready, 1);
      check("rst_mid_no_done", done_cnt - snap_done, 0);
      check("rst_mid_no_err", err_cnt - snap_err, 0);
      exp_q.delete();
      res_n = 1'b1;
      cyc(5);

      send(8'hFF, 1'b1);
      wait_rts();
      cyc(20);
      dev_clock(10);
      dev_ack();
      finish_frame("ff");
      check("par_ff", obs_vec[8], 1);

`ifdef PS2_TX_FILTER_EN
      send(8'h96, 1'b1);
      wait_rts();
      cyc(20);
      dev_clock(4);
      dev_clk = 1'b0;
      cyc(4);
      dev_clk = 1'b1;
      cyc(20);
      dev_clock(6);
      dev_ack();
      finish_frame("glitch");
      check("glitch_frame", obs_vec[9:0], 10'b11_1001_0110);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
